// File: rtl/bufm_pkg.sv
// Shared definitions for the packet-buffer write manager: line header codes,
// data width and write-FSM states.
package bufm_pkg;

  localparam int unsigned DATA_W = 134;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StWrite,
    StDisc
  } state_e;

endpackage

// File: rtl/pkt_bufm_wr_if.sv
// Packet stream, ID release and packet-RAM write bundle of pkt_bufm_wr.
// master = upstream/egress side, slave = the buffer manager.
interface pkt_bufm_wr_if
  import bufm_pkg::*;
#(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned LINE_W = 6
) ();

  logic [DATA_W-1:0]      in_data;
  logic                   in_data_wr;
  logic                   in_valid;
  logic                   in_valid_wr;
  logic [ID_W-1:0]        in_free_id;
  logic                   in_free_id_wr;
  logic [ID_W-1:0]        out_id;
  logic [4:0]             out_id_count;
  logic                   out_ram_wr;
  logic [ID_W+LINE_W-1:0] out_ram_addr;
  logic [DATA_W-1:0]      out_ram_data;
  logic                   out_err;

  modport master (
    output in_data, in_data_wr, in_valid, in_valid_wr, in_free_id, in_free_id_wr,
    input  out_id, out_id_count, out_ram_wr, out_ram_addr, out_ram_data, out_err
  );

  modport slave (
    input  in_data, in_data_wr, in_valid, in_valid_wr, in_free_id, in_free_id_wr,
    output out_id, out_id_count, out_ram_wr, out_ram_addr, out_ram_data, out_err
  );

endinterface

// File: rtl/free_id_fifo.sv
// Circular pool of free buffer IDs (Depth <= 31). A push is accepted when not
// full, or when full but popping in the same cycle.
module free_id_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned IdW   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic [IdW-1:0] push_id_i,
  input  logic           pop_i,
  output logic [IdW-1:0] rd_id_o,
  output logic [4:0]     count_o,
  output logic           full_o,
  output logic           empty_o
);

  logic [IdW-1:0] mem_q [32];
  logic [4:0]     wr_ptr_q, wr_ptr_d;
  logic [4:0]     rd_ptr_q, rd_ptr_d;
  logic [4:0]     count_q, count_d;
  logic           wr_ok, rd_ok;

  assign full_o  = (count_q == 5'(Depth));
  assign empty_o = (count_q == 5'd0);
  assign rd_id_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ok    = push_i && (!full_o || pop_i);
    rd_ok    = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = (wr_ptr_q == 5'(Depth - 1)) ? 5'd0 : wr_ptr_q + 5'd1;
    if (rd_ok) rd_ptr_d = (rd_ptr_q == 5'(Depth - 1)) ? 5'd0 : rd_ptr_q + 5'd1;
    count_d = count_q + {4'd0, wr_ok} - {4'd0, rd_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 5'd0;
      rd_ptr_q <= 5'd0;
      count_q  <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/pkt_bufm_wr.sv
// Packet-buffer write manager: allocates a buffer ID per packet and writes its lines
// to packet RAM at {id, line}. PKT_BUFM_STAT_EN adds packet/drop counters.
module pkt_bufm_wr
  import bufm_pkg::*;
#(
  parameter int unsigned NUM_BUF = 16,
  parameter int unsigned ID_W    = 8,
  parameter int unsigned LINE_W  = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  pkt_bufm_wr_if.slave bus
`ifdef PKT_BUFM_STAT_EN
  ,
  output logic [31:0]  out_pkt_cnt,
  output logic [31:0]  out_drop_cnt
`endif
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        out_id_q, out_id_d;
  logic [LINE_W:0]        line_q, line_d;
  logic                   ovf_q, ovf_d;
  logic [4:0]             init_q, init_d;
  logic                   rcy_v_q, rcy_v_d;
  logic                   hold_v_q, hold_v_d;
  logic [ID_W-1:0]        hold_id_q, hold_id_d;
  logic                   ram_wr_q, ram_wr_d;
  logic [ID_W+LINE_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]      ram_data_q, ram_data_d;
  logic                   err_q, err_d;

  logic [1:0]      hdr;
  logic            is_head, is_tail, pkt_good, rel_bad, rel_ok;
  logic            pop, push, rel_direct, no_id, ovf;
  logic [ID_W-1:0] push_id, fifo_rd_id;
  logic [4:0]      fifo_count;
  logic            fifo_full, fifo_empty;

  assign hdr      = bus.in_data[DATA_W-1 -: 2];
  assign is_head  = bus.in_data_wr && (hdr == HDR_HEAD);
  assign is_tail  = bus.in_data_wr && (hdr == HDR_TAIL);
  assign pkt_good = bus.in_valid_wr && bus.in_valid;
  assign rel_bad  = bus.in_free_id_wr && (bus.in_free_id >= ID_W'(NUM_BUF));
  assign rel_ok   = bus.in_free_id_wr && !rel_bad;

  always_comb begin
    state_d    = state_q;
    out_id_d   = out_id_q;
    line_d     = line_q;
    ovf_d      = ovf_q;
    init_d     = init_q;
    rcy_v_d    = 1'b0;
    hold_v_d   = hold_v_q;
    hold_id_d  = hold_id_q;
    ram_wr_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    push_id    = '0;
    rel_direct = 1'b0;
    no_id      = 1'b0;
    ovf        = 1'b0;

    unique case (state_q)
      StInit: begin
        push    = 1'b1;
        push_id = ID_W'(init_q);
        init_d  = init_q + 5'd1;
        if (init_q == 5'(NUM_BUF - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (is_head) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            out_id_d   = fifo_rd_id;
            ram_wr_d   = 1'b1;
            ram_addr_d = {fifo_rd_id, {LINE_W{1'b0}}};
            ram_data_d = bus.in_data;
            line_d     = {{LINE_W{1'b0}}, 1'b1};
            state_d    = StWrite;
          end else begin
            no_id   = 1'b1;
            ovf_d   = 1'b0;
            state_d = StDisc;
          end
        end
      end
      StWrite: begin
        if (bus.in_data_wr) begin
          if (line_q[LINE_W]) begin
            // Packet longer than 2**LINE_W lines: drop the rest, recycle the ID at tail.
            ovf = 1'b1;
            if (is_tail) begin
              rcy_v_d = 1'b1;
              state_d = StIdle;
            end else begin
              ovf_d   = 1'b1;
              state_d = StDisc;
            end
          end else begin
            ram_wr_d   = 1'b1;
            ram_addr_d = {out_id_q, line_q[LINE_W-1:0]};
            ram_data_d = bus.in_data;
            line_d     = line_q + {{LINE_W{1'b0}}, 1'b1};
            if (is_tail) begin
              state_d = StIdle;
              rcy_v_d = !pkt_good;
            end
          end
        end
      end
      StDisc: begin
        if (is_tail) begin
          rcy_v_d = ovf_q;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase

    // Pool write port priority: init fill, recycle, held release, new release.
    if (!push) begin
      if (rcy_v_q) begin
        push    = 1'b1;
        push_id = out_id_q;
      end else if (hold_v_q) begin
        push     = 1'b1;
        push_id  = hold_id_q;
        hold_v_d = 1'b0;
      end else if (rel_ok) begin
        push       = 1'b1;
        push_id    = bus.in_free_id;
        rel_direct = 1'b1;
      end
    end
    if (rel_ok && !rel_direct) begin
      if (hold_v_d) begin
        err_d = 1'b1;
      end else begin
        hold_v_d  = 1'b1;
        hold_id_d = bus.in_free_id;
      end
    end
    if (no_id || ovf || rel_bad || (push && fifo_full && !pop)) err_d = 1'b1;
  end

  free_id_fifo #(
    .Depth (NUM_BUF),
    .IdW   (ID_W)
  ) u_free_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_id_i (push_id),
    .pop_i     (pop),
    .rd_id_o   (fifo_rd_id),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      out_id_q   <= '0;
      line_q     <= '0;
      ovf_q      <= 1'b0;
      init_q     <= 5'd0;
      rcy_v_q    <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_id_q  <= '0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_id_q   <= out_id_d;
      line_q     <= line_d;
      ovf_q      <= ovf_d;
      init_q     <= init_d;
      rcy_v_q    <= rcy_v_d;
      hold_v_q   <= hold_v_d;
      hold_id_q  <= hold_id_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.out_id       = out_id_q;
  assign bus.out_id_count = fifo_count;
  assign bus.out_ram_wr   = ram_wr_q;
  assign bus.out_ram_addr = ram_addr_q;
  assign bus.out_ram_data = ram_data_q;
  assign bus.out_err      = err_q;

`ifdef PKT_BUFM_STAT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        wr_tail;

  always_comb begin
    wr_tail    = (state_q == StWrite) && is_tail && !line_q[LINE_W];
    pkt_cnt_d  = pkt_cnt_q + {31'd0, wr_tail && pkt_good};
    drop_cnt_d = drop_cnt_q + {31'd0, no_id || ovf || (wr_tail && !pkt_good)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_pkt_cnt  = pkt_cnt_q;
  assign out_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_bufm_wr.sv
// Self-checking bench for pkt_bufm_wr: directed packet table, corner sequences and a
// randomized phase checked against a queue-based pool model.
module tb_pkt_bufm_wr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_bufm_wr_if #(.ID_W(8), .LINE_W(6)) bus ();

`ifdef PKT_BUFM_STAT_EN
  logic [31:0] pkt_cnt, drop_cnt;
`endif

  pkt_bufm_wr #(
    .NUM_BUF (16),
    .ID_W    (8),
    .LINE_W  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PKT_BUFM_STAT_EN
    ,
    .out_pkt_cnt  (pkt_cnt),
    .out_drop_cnt (drop_cnt)
`endif
  );

  typedef struct {
    logic [13:0]  addr;
    logic [133:0] data;
  } wr_t;

  typedef struct {
    int len;
    bit valid;
    int exp_id;      // ID expected in RAM addresses, -1 = no writes
    int exp_out_id;
    int exp_cnt;
    int exp_err;
  } pkt_vec_t;

  wr_t exp_wr[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  err_seen = 0;

  task automatic chk(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // One clock; every RAM write is checked against the expected-write queue.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (bus.out_ram_wr === 1'b1) begin
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_err++;
        $display("FAIL ram_write: got unexpected write addr=%h, required none", bus.out_ram_addr);
      end else begin
        w = exp_wr.pop_front();
        if (bus.out_ram_addr !== w.addr || bus.out_ram_data !== w.data) begin
          n_err++;
          $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                   bus.out_ram_addr, bus.out_ram_data, w.addr, w.data);
        end
      end
    end
    if (bus.out_err === 1'b1) err_seen++;
  endtask

  task automatic idle_inputs();
    bus.in_data_wr    = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_valid_wr   = 1'b0;
    bus.in_free_id_wr = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit valid, input int exp_id, output int err_line);
    logic [133:0] d;
    logic [1:0]   hdr;
    err_line = -1;
    for (int i = 0; i < len; i++) begin
      hdr = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
      d = {hdr, 4'($urandom), $urandom, $urandom, $urandom, $urandom};
      if (exp_id >= 0 && i < 64) exp_wr.push_back('{addr: {8'(exp_id), 6'(i)}, data: d});
      bus.in_data     = d;
      bus.in_data_wr  = 1'b1;
      bus.in_valid_wr = (i == len - 1);
      bus.in_valid    = (i == len - 1) ? valid : 1'b0;
      tick();
      if (bus.out_err === 1'b1 && err_line < 0) err_line = i;
    end
    idle_inputs();
  endtask

  task automatic release_id(input int id);
    bus.in_free_id    = 8'(id);
    bus.in_free_id_wr = 1'b1;
    tick();
    bus.in_free_id_wr = 1'b0;
  endtask

  // Four idle cycles after a packet; out_id must stay put the whole time.
  task automatic gap_check(input string name, input int exp_out_id, input int exp_cnt);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({name, "_out_id"}, int'(bus.out_id), exp_out_id);
    end
    chk({name, "_count"}, int'(bus.out_id_count), exp_cnt);
  endtask

  pkt_vec_t vecs [18];

  initial begin
    int e0, el, id, len, idx, m_out_id, m_pkt, m_drop;
    bit valid, recycle, exp_e;
    int pool[$];
    int alloc[$];

    vecs[0] = '{len: 4, valid: 1'b1, exp_id: 0, exp_out_id: 0, exp_cnt: 15, exp_err: 0};
    vecs[1] = '{len: 3, valid: 1'b0, exp_id: 1, exp_out_id: 1, exp_cnt: 15, exp_err: 0};
    for (int k = 2; k <= 16; k++) begin
      vecs[k] = '{len: 2 + k % 5, valid: 1'b1, exp_id: (k <= 15) ? k : 1,
                  exp_out_id: (k <= 15) ? k : 1, exp_cnt: 16 - k, exp_err: 0};
    end
    vecs[17] = '{len: 3, valid: 1'b1, exp_id: -1, exp_out_id: 1, exp_cnt: 0, exp_err: 1};

    bus.in_data    = '0;
    bus.in_free_id = '0;
    idle_inputs();

    // Reset state
    tick();
    tick();
    chk("rst_out_id", int'(bus.out_id), 0);
    chk("rst_count", int'(bus.out_id_count), 0);
    chk("rst_ram_wr", int'(bus.out_ram_wr), 0);
    chk("rst_err", int'(bus.out_err), 0);
    chk("rst_addr", int'(bus.out_ram_addr), 0);
    rst_n = 1'b1;

    // Pool fill; a head during fill and a headless stream afterwards are both ignored
    for (int k = 1; k <= 20; k++) begin
      bus.in_data_wr  = (k == 3 || k == 4 || k == 18 || k == 19);
      bus.in_data     = {(k == 3) ? 2'b01 : ((k == 19) ? 2'b10 : 2'b11), 132'h5a5};
      bus.in_valid_wr = (k == 19);
      bus.in_valid    = (k == 19);
      tick();
      chk("init_count", int'(bus.out_id_count), (k < 16) ? k : 16);
    end
    idle_inputs();
    chk("init_err", err_seen, 0);

    // Directed packet table
    for (int v = 0; v < 18; v++) begin
      e0 = err_seen;
      send_pkt(vecs[v].len, vecs[v].valid, vecs[v].exp_id, el);
      gap_check($sformatf("vec%0d", v), vecs[v].exp_out_id, vecs[v].exp_cnt);
      chk($sformatf("vec%0d_err", v), err_seen - e0, vecs[v].exp_err);
    end

    // Release ID 5 into the empty pool
    release_id(5);
    tick();
    chk("rel5_count", int'(bus.out_id_count), 1);

    // 70-line packet: 64 writes, error on line 65, ID recycled
    e0 = err_seen;
    send_pkt(70, 1'b1, 5, el);
    chk("ovf_err_line", el, 64);
    gap_check("ovf", 5, 1);
    chk("ovf_err", err_seen - e0, 1);

    // Release in the same cycle as an invalid-tail recycle
    e0 = err_seen;
    send_pkt(3, 1'b0, 5, el);
    release_id(0);
    tick();
    chk("dual_push_count", int'(bus.out_id_count), 2);
    chk("dual_push_err", err_seen - e0, 0);

    // Out-of-range releases
    e0 = err_seen;
    release_id(20);
    tick();
    chk("bad_rel20_err", err_seen - e0, 1);
    chk("bad_rel20_count", int'(bus.out_id_count), 2);
    e0 = err_seen;
    release_id(16);
    tick();
    chk("bad_rel16_err", err_seen - e0, 1);
    chk("bad_rel16_count", int'(bus.out_id_count), 2);

    // Pool order is recycle (5) before release (0)
    send_pkt(2, 1'b1, 5, el);
    gap_check("order", 5, 1);

    // Asynchronous reset in the middle of a packet
    exp_wr.push_back('{addr: {8'd0, 6'd0}, data: {2'b01, 132'h11}});
    exp_wr.push_back('{addr: {8'd0, 6'd1}, data: {2'b11, 132'h22}});
    bus.in_data_wr = 1'b1;
    bus.in_data    = {2'b01, 132'h11};
    tick();
    bus.in_data    = {2'b11, 132'h22};
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", int'(bus.out_id_count), 0);
    chk("arst_ram_wr", int'(bus.out_ram_wr), 0);
    chk("arst_out_id", int'(bus.out_id), 0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    chk("rearm_count", int'(bus.out_id_count), 16);

    // Randomized traffic against a queue model of the pool
    pool.delete();
    alloc.delete();
    for (int i = 0; i < 16; i++) pool.push_back(i);
    m_out_id = 0;
    m_pkt    = 0;
    m_drop   = 0;
    for (int it = 0; it < 80; it++) begin
      if ($urandom % 4 == 0 && alloc.size() > 0) begin
        idx = $urandom_range(0, alloc.size() - 1);
        id  = alloc[idx];
        alloc.delete(idx);
        pool.push_back(id);
        release_id(id);
        gap_check("rnd_rel", m_out_id, pool.size());
      end else begin
        len     = ($urandom % 8 == 0) ? $urandom_range(65, 70) : $urandom_range(2, 9);
        valid   = ($urandom % 3 != 0);
        recycle = 1'b0;
        exp_e   = 1'b0;
        e0      = err_seen;
        if (pool.size() == 0) begin
          id    = -1;
          exp_e = 1'b1;
          m_drop++;
        end else begin
          id       = pool.pop_front();
          m_out_id = id;
          if (len > 64) begin
            exp_e   = 1'b1;
            recycle = 1'b1;
            m_drop++;
          end else if (!valid) begin
            recycle = 1'b1;
            m_drop++;
          end else begin
            alloc.push_back(id);
            m_pkt++;
          end
        end
        send_pkt(len, valid, id, el);
        if (recycle) pool.push_back(id);
        if (recycle && alloc.size() > 0 && $urandom % 2 == 1) begin
          idx = $urandom_range(0, alloc.size() - 1);
          pool.push_back(alloc[idx]);
          release_id(alloc[idx]);
          alloc.delete(idx);
        end
        gap_check("rnd_pkt", m_out_id, pool.size());
        chk("rnd_err", err_seen - e0, int'(exp_e));
      end
    end

`ifdef PKT_BUFM_STAT_EN
    chk("stat_pkt_cnt", int'(pkt_cnt), m_pkt);
    chk("stat_drop_cnt", int'(drop_cnt), m_drop);
`endif
    chk("pending_writes", exp_wr.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_bufm_wr.md
Name: pkt_bufm_wr

Overview:
- Packet-buffer write manager directly downstream of the ingress packet stage.
- Consumes the 134-bit packet stream plus its tail valid flag, and allocates a buffer ID per packet from a free-ID pool.
- Writes packet lines into the shared packet RAM at {ID, line} and presents the allocated ID and free-buffer count back upstream.
- Recycles IDs of discarded packets internally; accepts released IDs from the egress side.

Parameters:
- NUM_BUF, 16, number of packet buffers (1..31).
- ID_W, 8, width of buffer ID.
- LINE_W, 6, line index width; a packet is at most 2**LINE_W lines.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  134  packet line; [133:132] = 01 head, 11 body, 10 tail
- in_data_wr  in  1  in_data qualifier
- in_valid  in  1  packet good flag, sampled with in_valid_wr
- in_valid_wr  in  1  in_valid qualifier; coincides with the tail line
- in_free_id  in  ID_W  ID released by egress
- in_free_id_wr  in  1  release strobe
- out_id  out  ID_W  ID of the current/last accepted packet
- out_id_count  out  5  number of free IDs in pool
- out_ram_wr  out  1  packet RAM write enable
- out_ram_addr  out  ID_W+LINE_W  {id[ID_W-1:0], line}
- out_ram_data  out  134  RAM write data
- out_err  out  1  one-cycle pulse: overflow, no-ID drop, or bad release

Behaviour:
- Reset: all outputs 0; state INIT; pool empty.
- INIT: pushes IDs 0..NUM_BUF-1, one per cycle; out_id_count ramps to NUM_BUF; then IDLE.
  - Input data during INIT is ignored, including a head; the line stream stays discarded until the next head seen in IDLE.
- IDLE, head (in_data_wr=1, hdr=01):
  - Pool non-empty: pop ID; next cycle out_id=ID, out_ram_wr=1, addr={ID,0}, data=line; line cnt=1; go WRITE.
  - Pool empty: out_err pulse; go DISC; out_id unchanged.
- Non-head lines in IDLE are ignored.
- WRITE:
  - Each in_data_wr line is written with 1-cycle latency at {ID, line cnt}; line cnt increments.
  - Tail line is written, then return to IDLE.
  - Tail with in_valid=0: ID is pushed back to the pool the cycle after the tail.
  - Tail with in_valid=1: ID stays allocated until released via in_free_id.
- Overflow: a line arriving when line cnt = 2**LINE_W is not written; out_err pulse; go DISC; ID is recycled at the tail.
- DISC: no RAM writes; on tail go IDLE; recycle the held ID if the packet overflowed.
- out_id holds its value from one cycle after the head until the next accepted head. The downstream metadata capture relies on it staying stable ≥3 cycles after the tail.
- Pool FIFO (depth NUM_BUF):
  - Push sources: internal recycle and in_free_id_wr. Simultaneous pushes: recycle first, release next cycle (1-entry hold register).
  - Simultaneous pop and push: both take effect; count unchanged.
  - Push when count=NUM_BUF, or release ID ≥ NUM_BUF: ignored, out_err pulse.
- out_id_count is registered and reflects the pool after the current cycle's push/pop.
- Async reset mid-packet: pool is re-initialised; the partial packet is lost.

Optional Feature:
- PKT_BUFM_STAT_EN defined adds outputs:
  - out_pkt_cnt[31:0]: accepted valid packets.
  - out_drop_cnt[31:0]: invalid + no-ID + overflow packets.
  - Both are wrapping counters, reset to 0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bufm_pkg:
  - Header codes HDR_HEAD=2'b01, HDR_BODY=2'b11, HDR_TAIL=2'b10.
  - DATA_W=134; state encodings INIT/IDLE/WRITE/DISC.
- Sub-module free_id_fifo: circular FIFO of IDs with push/pop/count and full/empty flags.

Test Plan:
- Release reset, idle 20 cycles → out_id_count reaches 16 after 16 cycles; no RAM writes.
- 4-line packet, tail in_valid=1 → RAM writes addrs {0,0}..{0,3}; out_id=0 from cycle after head; out_id_count 16→15.
- 3-line packet, tail in_valid=0 → 3 writes under ID 1; ID 1 pushed back; count returns to 15.
- Allocate all 16 via valid packets, send a 17th → no RAM writes; out_err pulse; out_id unchanged; count stays 0; then release ID 5 → count 1 and the next packet gets ID 5.
- 70-line packet with LINE_W=6 → 64 writes, out_err on line 65, ID recycled at tail, count restored.
- in_free_id_wr on the same cycle as an invalid-tail recycle → both IDs returned within 2 cycles; count +2; release of ID 20 → out_err, count unchanged.
